kbd_char_fifo: RTL
==================

# kbd_char_fifo

Downstream consumer of the keyboard decoder's `ascii_key` level output. It turns the level into discrete character events: one event per new key press, plus optional typematic auto-repeat while a key is held. Events are buffered in a small FIFO that the CPU-side MMIO keyboard register drains one byte at a time. This decouples human typing rate and key-hold duration from software polling rate.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, at least 2.
- `REPEAT_DELAY`, 25_000_000: cycles from press to first repeat (500 ms at 50 MHz); at least 2.
- `REPEAT_PERIOD`, 2_500_000: cycles between repeats (50 ms at 50 MHz); at least 2.
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `ascii_key`  in  8  current decoded key; 0 means no key held.
- `rd_en`  in  1  pop the head entry this cycle.
- `clr_ovf`  in  1  clear the sticky overflow flag.
- `rd_data`  out  8  head entry (first-word fall-through); 0 when empty.
- `empty`  out  1  FIFO holds no entries.
- `full`  out  1  FIFO holds `DEPTH` entries.
- `count`  out  $clog2(DEPTH)+1  number of stored entries.
- `overflow`  out  1  sticky: a press event was dropped because the FIFO was full.

## Operation
- Internal `last_key` register, reset 0, loaded with `ascii_key` every cycle.
- **Press event:** `ascii_key != 0 && ascii_key != last_key`. This covers both 0→A and a direct A→B change. The event pushes `ascii_key`.
- **Release:** `ascii_key == 0`. No push. Repeat FSM returns to IDLE.
- **Repeat FSM** (`KBD_REPEAT_EN` only), with states IDLE, DELAY, REPEAT and a counter `rpt_cnt`:
  - IDLE → DELAY on a press event; counter cleared.
  - DELAY: counter increments. When it reaches `REPEAT_DELAY-1`, push `last_key`, clear the counter, go to REPEAT.
  - REPEAT: when the counter reaches `REPEAT_PERIOD-1`, push `last_key` and clear the counter.
  - From any state, a press event restarts DELAY with the counter cleared.
  - From any state, a release goes to IDLE.
- **Push when full:**
  - A press push is dropped and sets `overflow`.
  - A repeat push is dropped silently; `overflow` is unchanged.
- **Pop on empty:** `rd_en` is ignored; pointers and `count` are unchanged.
- **Simultaneous push and pop:**
  - Both are performed. `count` is unchanged.
  - If the FIFO was full, the push is accepted and `overflow` is not set.
  - If the FIFO was empty, the pop is ignored and the push is performed.
- **Overflow flag:** if `clr_ovf` and an overflowing press coincide, `overflow` stays 1 (set wins).
- **Pointers:** `$clog2(DEPTH)` bits each; they wrap naturally. `count` distinguishes full from empty.

## Timing
- Reset values: `rd_data`=0, `empty`=1, `full`=0, `count`=0, `overflow`=0, `last_key`=0, FSM in IDLE, `rpt_cnt`=0.
- Reset mid-hold: all state is cleared. If the key is still held after reset, it produces a fresh press event on the first post-reset edge, because `last_key` is 0.
- Push latency: an event qualifying before edge k is stored at edge k. After edge k, `empty`, `count` and `rd_data` reflect the new entry.
- Pop: `rd_en` high before edge k removes the head at edge k. The next entry appears on `rd_data` after edge k.
- Repeat timing: the first repeat is pushed exactly `REPEAT_DELAY` cycles after the press push. Each further repeat follows `REPEAT_PERIOD` cycles later.
- At most one push per cycle. A press event takes priority over a repeat in the same cycle.

## Configuration
- `KBD_REPEAT_EN` defined: the repeat FSM and counter are built, and the `REPEAT_*` parameters are used.
- `KBD_REPEAT_EN` undefined:
  - Only press events push.
  - The FSM and counter are absent; the `REPEAT_*` parameters are ignored.
  - A held key yields exactly one entry.

## Structure
- Package `kbd_pkg` holds:
  - the `rpt_state_t` enum (IDLE, DELAY, REPEAT);
  - default timing constants `KBD_REPEAT_DELAY_DEF` and `KBD_REPEAT_PERIOD_DEF`;
  - the `KBD_NO_KEY` = 8'h00 constant.
- Sub-module `kbd_fifo`: parameterised synchronous first-word fall-through FIFO providing push, pop, `count`, `full` and `empty`.
- `kbd_char_fifo` contains event detection, the repeat FSM and overflow handling.

## Test plan
Use `DEPTH`=4, `REPEAT_DELAY`=10, `REPEAT_PERIOD`=4 unless stated otherwise.
- **Reset:** assert `rst` 2 cycles → `empty`=1, `count`=0, `rd_data`=0, `overflow`=0.
- **Press / pop:** `ascii_key` 0→8'h61 held 3 cycles, then 0 → exactly one entry; `rd_data`=8'h61, `count`=1. Pulse `rd_en` → `empty`=1.
- **Direct key change:** 8'h61→8'h62 with no 0 between → two entries, 8'h61 then 8'h62, in order.
- **Repeat** (`KBD_REPEAT_EN` defined): hold 8'h61 for 20 cycles → pushes at press+0, +10, +14 and +18, giving `count`=4 and `full`=1. No `overflow` from the later repeat attempt.
- **No repeat** (`KBD_REPEAT_EN` undefined): hold 8'h61 for 20 cycles → `count`=1.
- **Overflow:**
  - Five distinct presses with no pops → `count`=4, `overflow`=1, entries are the first four keys.
  - Sixth press together with `rd_en` → accepted, `count`=4.
  - Pulse `clr_ovf` → `overflow`=0.

Source files
------------

// File: rtl/kbd_pkg.sv
// rtl/kbd_pkg.sv - shared types and constants for the keyboard character FIFO
package kbd_pkg;

    // Auto-repeat FSM states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rpt_state_t;

    // Default typematic timing at 50 MHz: 500 ms initial delay, 50 ms period
    localparam int KBD_REPEAT_DELAY_DEF  = 25_000_000;
    localparam int KBD_REPEAT_PERIOD_DEF = 2_500_000;

    // Decoder output value meaning "no key held"
    localparam logic [7:0] KBD_NO_KEY = 8'h00;

endpackage

// File: rtl/kbd_fifo.sv
// rtl/kbd_fifo.sv - synchronous first-word fall-through FIFO with occupancy count
module kbd_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic [W-1:0]           i_push_data,
    input  logic                   i_pop,
    output logic [W-1:0]           o_rd_data,
    output logic                   o_empty,
    output logic                   o_full,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_empty;
    logic          w_full;
    logic          w_do_pop;
    logic          w_do_push;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == (AW+1)'(DEPTH));
    // A pop on empty is ignored; a push on full is only accepted when a pop frees a slot
    assign w_do_pop  = i_pop && !w_empty;
    assign w_do_push = i_push && (!w_full || w_do_pop);

    // Storage write; contents need no reset because the head is masked while empty
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointers wrap naturally; count disambiguates full from empty
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + (AW+1)'(1);
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - (AW+1)'(1);
            end
        end
    end

    assign o_rd_data = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_empty   = w_empty;
    assign o_full    = w_full;
    assign o_count   = r_count;

endmodule

// File: rtl/kbd_char_fifo.sv
// rtl/kbd_char_fifo.sv - key press / auto-repeat event generator feeding a character FIFO (option: KBD_REPEAT_EN)
module kbd_char_fifo
    import kbd_pkg::*;
#(
    parameter int DEPTH         = 16,
    parameter int REPEAT_DELAY  = KBD_REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD = KBD_REPEAT_PERIOD_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             ascii_key,
    input  logic                   rd_en,
    input  logic                   clr_ovf,
    output logic [7:0]             rd_data,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow
);

    logic [7:0] r_last_key;
    logic       r_overflow;
    logic       w_press;
    logic       w_release;
    logic       w_rpt_push;
    logic       w_push;
    logic [7:0] w_push_data;
    logic       w_full;
    logic       w_set_ovf;

    // A press is any change to a non-zero key, including a direct key-to-key change
    assign w_press   = (ascii_key != KBD_NO_KEY) && (ascii_key != r_last_key);
    assign w_release = (ascii_key == KBD_NO_KEY);

    // Previous-cycle key for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_key <= KBD_NO_KEY;
        end else begin
            r_last_key <= ascii_key;
        end
    end

`ifdef KBD_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int CW      = $clog2(RPT_MAX);

    rpt_state_t    r_state;
    logic [CW-1:0] r_rpt_cnt;
    logic          w_delay_done;
    logic          w_period_done;

    assign w_delay_done  = (r_state == DELAY)  && (r_rpt_cnt == CW'(REPEAT_DELAY - 1));
    assign w_period_done = (r_state == REPEAT) && (r_rpt_cnt == CW'(REPEAT_PERIOD - 1));

    // Typematic FSM: release and press override whatever the counter is doing
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_rpt_cnt <= '0;
        end else if (w_release) begin
            r_state   <= IDLE;
            r_rpt_cnt <= '0;
        end else if (w_press) begin
            r_state   <= DELAY;
            r_rpt_cnt <= '0;
        end else begin
            case (r_state)
                DELAY: begin
                    if (w_delay_done) begin
                        r_state   <= REPEAT;
                        r_rpt_cnt <= '0;
                    end else begin
                        r_rpt_cnt <= r_rpt_cnt + CW'(1);
                    end
                end
                REPEAT: begin
                    if (w_period_done) begin
                        r_rpt_cnt <= '0;
                    end else begin
                        r_rpt_cnt <= r_rpt_cnt + CW'(1);
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_rpt_cnt <= '0;
                end
            endcase
        end
    end

    // Press wins over a repeat landing in the same cycle; a release suppresses it
    assign w_rpt_push = !w_release && !w_press && (w_delay_done || w_period_done);
`else
    logic w_unused_rpt;

    assign w_rpt_push   = 1'b0;
    assign w_unused_rpt = (REPEAT_DELAY != REPEAT_PERIOD);
`endif

    assign w_push      = w_press || w_rpt_push;
    assign w_push_data = w_press ? ascii_key : r_last_key;

    // Only a dropped press is reported; a pop in the same cycle makes room, so nothing drops
    assign w_set_ovf = w_press && w_full && !rd_en;

    // Sticky overflow flag; setting takes precedence over clearing
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (w_set_ovf) begin
            r_overflow <= 1'b1;
        end else if (clr_ovf) begin
            r_overflow <= 1'b0;
        end
    end

    kbd_fifo #(
        .DEPTH (DEPTH),
        .W     (8)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (rd_en),
        .o_rd_data   (rd_data),
        .o_empty     (empty),
        .o_full      (w_full),
        .o_count     (count)
    );

    assign full     = w_full;
    assign overflow = r_overflow;

endmodule
